// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential non-restoring divider.
//   DIV_WIDTH    - default divisor/quotient/remainder width
//   div_state_e  - FSM state encoding (IDLE/ITER/FIX/DONE)
//   div_cnt_w()  - iteration counter width for a given WIDTH
package div_pkg;

    localparam int DIV_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter must hold 0..WIDTH.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/nonrestoring_divider_if.sv
// nonrestoring_divider_if: load/ready handshake bundle of the divider.
//   master: load, dividend (2*WIDTH), divisor (WIDTH) out; results in
//   slave : operands in; quotient, remainder, ready, err out
interface nonrestoring_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    logic                 load;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 ready;
    logic                 err;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, ready, err
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, ready, err
    );
endinterface

// File: rtl/div_addsub.sv
// div_addsub: N-bit adder/subtractor. sub=1 computes a-b as a + ~b + 1
// (operand inversion plus carry-in), sub=0 computes a+b.
//   a, b : operands
//   sub  : 1 = subtract
//   sum  : result, wraps modulo 2^N
module div_addsub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    assign sum = a + (b ^ {N{sub}}) + N'(sub);
endmodule

// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: sequential unsigned non-restoring divider,
// one quotient bit per clock, 2*WIDTH / WIDTH -> WIDTH q, WIDTH r.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of nonrestoring_divider_if
//                (load, dividend, divisor -> quotient, remainder, ready, err)
// Optional macro DIV_ERR_CHECK_EN: flag divide-by-zero / quotient overflow
// at load and finish one clock later with err=1, quotient all ones, rem 0.
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nonrestoring_divider_if.slave   bus
);
    localparam int CNT_W = div_cnt_w(WIDTH);
    localparam int RW    = WIDTH + 2;

    div_state_e       state_q, state_d;
    logic [RW-1:0]    r_q, r_d;        // signed partial remainder
    logic [WIDTH-1:0] q_q, q_d;        // dividend low half / quotient bits
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             errp_q, errp_d;  // error seen at load, resolved next cycle
    logic             err_chk;

    logic [RW-1:0]    as_a, as_sum;
    logic             as_sub;

    // ITER works on the left-shifted {R,Q}; FIX adds D back to R.
    always_comb begin
        if (state_q == FIX) begin
            as_a   = r_q;
            as_sub = 1'b0;
        end else begin
            as_a   = {r_q[RW-2:0], q_q[WIDTH-1]};
            as_sub = ~r_q[RW-1];
        end
    end

    div_addsub #(.N(RW)) u_addsub (
        .a   (as_a),
        .b   ({2'b00, d_q}),
        .sub (as_sub),
        .sum (as_sum)
    );

    always_comb begin
`ifdef DIV_ERR_CHECK_EN
        err_chk = (bus.divisor == '0) ||
                  (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
`else
        err_chk = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        errp_d  = errp_q;
        if (bus.load) begin
            r_d     = {2'b00, bus.dividend[2*WIDTH-1:WIDTH]};
            q_d     = bus.dividend[WIDTH-1:0];
            d_d     = bus.divisor;
            cnt_d   = '0;
            state_d = ITER;
            err_d   = 1'b0;
            errp_d  = err_chk;
        end else begin
            case (state_q)
                ITER: begin
                    if (errp_q) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        errp_d  = 1'b0;
                    end else begin
                        r_d   = as_sum;
                        q_d   = {q_q[WIDTH-2:0], ~as_sum[RW-1]};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                    end
                end
                FIX: begin
                    if (r_q[RW-1]) r_d = as_sum;
                    quot_d  = q_q;
                    rem_d   = r_q[RW-1] ? as_sum[WIDTH-1:0] : r_q[WIDTH-1:0];
                    state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
    assign bus.err       = err_q;

endmodule
